// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: column-multiplexed 8x8 RGB LED matrix scanner.
// Two pixel banks; the front bank is displayed while the back bank is written.
// Each column is blanked for BLANK_TICKS clocks, then shown for SHOW_TICKS clocks.
// Bank swaps take effect only at the frame boundary (column 7 -> column 0).
module matrix_scan_ctrl #(
    parameter int BLANK_TICKS = 2,
    parameter int SHOW_TICKS  = 5000
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       wr_en,
    input  logic [2:0] wr_line,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_b,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic [3:0] COMM,
    output logic       frame_start
);

    // Tick counter only has to reach the longer of the two phase lengths minus one.
    localparam int MAX_TICKS = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
    localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Pixel storage, addressed as {bank, line}; bit x of a line is column x.
    logic [7:0] bank_r [0:15];
    logic [7:0] bank_g [0:15];
    logic [7:0] bank_b [0:15];

    state_t       state, state_nxt;
    logic [2:0]   col, col_nxt;
    logic [TW-1:0] tick, tick_nxt;
    logic         front_sel, front_nxt;
    // Cleared by reset so the first clock after release re-enters column 0
    // with a frame_start pulse instead of silently continuing the blank.
    logic         run;
    logic         frame_wrap;
    logic         swap_go;

    logic [7:0]   data_r_nxt, data_g_nxt, data_b_nxt;
    logic [3:0]   comm_nxt;
    logic         ack_nxt, fs_nxt;

    // Back-bank writes; the bank chosen is the back bank before any swap on this edge.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < 16; i++) begin
                bank_r[i] <= 8'h00;
                bank_g[i] <= 8'h00;
                bank_b[i] <= 8'h00;
            end
        end else if (wr_en) begin
            bank_r[{~front_sel, wr_line}] <= wr_r;
            bank_g[{~front_sel, wr_line}] <= wr_g;
            bank_b[{~front_sel, wr_line}] <= wr_b;
        end
    end

    // Scan state register: phase, column, tick count and front-bank selector.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state     <= BLANK;
            col       <= 3'd0;
            tick      <= '0;
            front_sel <= 1'b0;
            run       <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            tick      <= tick_nxt;
            front_sel <= front_nxt;
            run       <= 1'b1;
        end
    end

    // Next-state logic: BLANK/SHOW sequencing, column advance and frame-boundary swap.
    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        tick_nxt   = tick;
        front_nxt  = front_sel;
        frame_wrap = 1'b0;
        swap_go    = 1'b0;
        if (!run) begin
            state_nxt  = BLANK;
            col_nxt    = 3'd0;
            tick_nxt   = '0;
            frame_wrap = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (tick == BLANK_LAST) begin
                        state_nxt = SHOW;
                        tick_nxt  = '0;
                    end else begin
                        tick_nxt = tick + 1'b1;
                    end
                end
                SHOW: begin
                    if (tick == SHOW_LAST) begin
                        state_nxt = BLANK;
                        tick_nxt  = '0;
                        col_nxt   = col + 3'd1;
                        if (col == 3'd7) begin
                            frame_wrap = 1'b1;
                            if (swap_req) begin
                                swap_go   = 1'b1;
                                front_nxt = ~front_sel;
                            end
                        end
                    end else begin
                        tick_nxt = tick + 1'b1;
                    end
                end
                default: begin
                    state_nxt = BLANK;
                    tick_nxt  = '0;
                end
            endcase
        end
    end

    // Output decode of the state being entered, so registered outputs carry no extra latency.
    // Columns only change on BLANK entry, where front_sel may flip; inside SHOW the
    // front bank is never written, so sampling it at SHOW entry holds for the column.
    always_comb begin
        data_r_nxt = 8'hFF;
        data_g_nxt = 8'hFF;
        data_b_nxt = 8'hFF;
        comm_nxt   = {1'b0, col_nxt};
        ack_nxt    = swap_go;
        fs_nxt     = frame_wrap;
        if (state_nxt == SHOW) begin
            comm_nxt = {1'b1, col_nxt};
            for (int y = 0; y < 8; y++) begin
                data_r_nxt[y] = ~bank_r[{front_sel, 3'(y)}][col_nxt];
                data_g_nxt[y] = ~bank_g[{front_sel, 3'(y)}][col_nxt];
                data_b_nxt[y] = ~bank_b[{front_sel, 3'(y)}][col_nxt];
            end
        end
    end

    // Output registers; reset leaves the matrix dark and deselected.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            DATA_R      <= 8'hFF;
            DATA_G      <= 8'hFF;
            DATA_B      <= 8'hFF;
            COMM        <= 4'b0000;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            DATA_R      <= data_r_nxt;
            DATA_G      <= data_g_nxt;
            DATA_B      <= data_b_nxt;
            COMM        <= comm_nxt;
            swap_ack    <= ack_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl with short phases (2 blank / 4 show clocks).
// A frame-position reference model predicts every output each cycle.
module tb_matrix_scan_ctrl;

    localparam int BT     = 2;
    localparam int ST     = 4;
    localparam int COLT   = BT + ST;
    localparam int PERIOD = 8 * COLT;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_line = 3'd0;
    logic [7:0] wr_r = 8'h00, wr_g = 8'h00, wr_b = 8'h00;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic [7:0] DATA_R, DATA_G, DATA_B;
    logic [3:0] COMM;
    logic       frame_start;

    matrix_scan_ctrl #(.BLANK_TICKS(BT), .SHOW_TICKS(ST)) dut (
        .CLK(CLK), .CLR(CLR), .wr_en(wr_en), .wr_line(wr_line),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .swap_req(swap_req),
        .swap_ack(swap_ack), .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
        .COMM(COMM), .frame_start(frame_start)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model: cycle index since release, front bank index, bank contents.
    int         mt = -1;
    int         front = 0;
    logic [7:0] mr [2][8];
    logic [7:0] mg [2][8];
    logic [7:0] mb [2][8];
    logic [3:0] e_comm = 4'h0;
    logic       e_fs = 1'b0, e_ack = 1'b0;
    logic [7:0] e_dr = 8'hFF, e_dg = 8'hFF, e_db = 8'hFF;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, mt);
        end
    endtask

    task automatic model_edge(input logic clr, input logic we, input logic [2:0] ln,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic sw);
        int pos, col;
        logic show, boundary;
        if (clr) begin
            for (int k = 0; k < 2; k++)
                for (int y = 0; y < 8; y++) begin
                    mr[k][y] = 8'h00; mg[k][y] = 8'h00; mb[k][y] = 8'h00;
                end
            front = 0; mt = -1;
            e_comm = 4'h0; e_fs = 1'b0; e_ack = 1'b0;
            e_dr = 8'hFF; e_dg = 8'hFF; e_db = 8'hFF;
        end else begin
            mt++;
            boundary = (mt > 0) && (mt % PERIOD == 0);
            if (we) begin
                mr[1-front][ln] = r; mg[1-front][ln] = g; mb[1-front][ln] = b;
            end
            e_ack = boundary && sw;
            if (e_ack) front = 1 - front;
            pos  = mt % PERIOD;
            col  = pos / COLT;
            show = (pos % COLT) >= BT;
            e_fs = (pos == 0);
            e_comm = {show, 3'(col)};
            for (int y = 0; y < 8; y++) begin
                e_dr[y] = show ? ~mr[front][y][col] : 1'b1;
                e_dg[y] = show ? ~mg[front][y][col] : 1'b1;
                e_db[y] = show ? ~mb[front][y][col] : 1'b1;
            end
        end
    endtask

    task automatic step(input logic clr, input logic we, input logic [2:0] ln,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic sw);
        CLR = clr; wr_en = we; wr_line = ln; wr_r = r; wr_g = g; wr_b = b; swap_req = sw;
        @(posedge CLK);
        model_edge(clr, we, ln, r, g, b, sw);
        #1;
        chk("m_comm", {4'h0, COMM}, {4'h0, e_comm});
        chk("m_fs", {7'h0, frame_start}, {7'h0, e_fs});
        chk("m_ack", {7'h0, swap_ack}, {7'h0, e_ack});
        chk("m_dr", DATA_R, e_dr);
        chk("m_dg", DATA_G, e_dg);
        chk("m_db", DATA_B, e_db);
    endtask

    task automatic idle(input logic sw);
        step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, sw);
    endtask

    task automatic run_to(input int p, input logic sw);
        for (int n = 0; n < 200; n++) begin
            idle(sw);
            if (mt >= 0 && mt % PERIOD == p) return;
        end
        checks++; failures++;
        $display("FAIL run_to_timeout actual=%0d required=%0d", mt % PERIOD, p);
    endtask

    typedef struct packed {
        logic       clr;
        logic       wr;
        logic [2:0] ln;
        logic [7:0] r;
        logic       sw;
        logic [3:0] comm;
        logic       fs;
        logic       ack;
        logic [7:0] dr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int acks, bad, early;
        // Reset with concurrent write/swap, then the opening columns of the scan.
        tbl[0]  = '{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, 4'h0, 1'b0, 1'b0, 8'hFF};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 8'hFF};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'hFF};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 8'hFF};
        tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h8, 1'b0, 1'b0, 8'hFF};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 4'h8, 1'b0, 1'b0, 8'hFF};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h8, 1'b0, 1'b0, 8'hFF};
        tbl[7]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h8, 1'b0, 1'b0, 8'hFF};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h1, 1'b0, 1'b0, 8'hFF};
        tbl[9]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h1, 1'b0, 1'b0, 8'hFF};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'h9, 1'b0, 1'b0, 8'hFF};
        tbl[11] = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 4'h9, 1'b0, 1'b0, 8'hFF};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].clr, tbl[i].wr, tbl[i].ln, tbl[i].r, 8'h00, 8'h00, tbl[i].sw);
            chk("t_comm", {4'h0, COMM}, {4'h0, tbl[i].comm});
            chk("t_fs", {7'h0, frame_start}, {7'h0, tbl[i].fs});
            chk("t_ack", {7'h0, swap_ack}, {7'h0, tbl[i].ack});
            chk("t_dr", DATA_R, tbl[i].dr);
        end
        // Full first frame stays dark and 48 cycles long.
        run_to(0, 1'b0);
        chk("period_fs", {7'h0, frame_start}, 8'h01);

        // Write line 3 red column 0, then hold a swap request until granted.
        run_to(10, 1'b0);
        step(1'b0, 1'b1, 3'd3, 8'h01, 8'h00, 8'h00, 1'b0);
        acks = 0;
        for (int n = 0; n < 100 && acks == 0; n++) begin
            idle(1'b1);
            if (swap_ack) acks = 1;
        end
        chk("ack_seen", 8'(acks), 8'd1);
        chk("ack_with_fs", {7'h0, frame_start}, 8'h01);
        idle(1'b0);
        chk("ack_width", {7'h0, swap_ack}, 8'h00);
        idle(1'b0);
        chk("swap_dr", DATA_R, 8'hF7);
        chk("swap_dg", DATA_G, 8'hFF);
        chk("swap_db", DATA_B, 8'hFF);
        run_to(8, 1'b0);
        chk("col1_dr", DATA_R, 8'hFF);

        // Back-bank write without a swap must not reach the display.
        step(1'b0, 1'b1, 3'd0, 8'h00, 8'hFF, 8'h00, 1'b0);
        bad = 0;
        for (int n = 0; n < 2 * PERIOD; n++) begin
            idle(1'b0);
            if (DATA_G !== 8'hFF) bad = 1;
        end
        chk("iso_g", 8'(bad), 8'd0);

        // Request raised in column 4 waits for the column-0 boundary.
        run_to(24, 1'b0);
        early = 0;
        while (mt % PERIOD != PERIOD - 1) begin
            idle(1'b1);
            if (swap_ack) early = 1;
        end
        chk("early_ack", 8'(early), 8'd0);
        idle(1'b1);
        chk("bnd_ack", {7'h0, swap_ack}, 8'h01);
        // Second request dropped in column 5 is never granted.
        run_to(18, 1'b0);
        run_to(30, 1'b1);
        early = 0;
        for (int n = 0; n < PERIOD && (mt % PERIOD) != 0; n++) begin
            idle(1'b0);
            if (swap_ack) early = 1;
        end
        chk("dropped_ack", 8'(early), 8'd0);
        idle(1'b0); idle(1'b0);
        chk("front_keep", DATA_G, 8'hFE);

        // Held request: one grant per frame, banks alternate.
        acks = 0;
        for (int n = 0; n < 3 * PERIOD; n++) begin
            idle(1'b1);
            if (swap_ack) acks++;
        end
        chk("held_acks", 8'(acks), 8'd3);
        chk("held_front", DATA_G, 8'hFF);

        // Randomized traffic checked by the model, with occasional resets.
        for (int n = 0; n < 900; n++) begin
            step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 5) == 0));
        end

        // Reset in column 5 SHOW, colliding with a write and a swap request.
        run_to(33, 1'b0);
        step(1'b1, 1'b1, 3'd2, 8'hAA, 8'h55, 8'hFF, 1'b1);
        chk("rst_comm", {4'h0, COMM}, 8'h00);
        chk("rst_dr", DATA_R, 8'hFF);
        chk("rst_ack", {7'h0, swap_ack}, 8'h00);
        chk("rst_fs", {7'h0, frame_start}, 8'h00);
        idle(1'b0);
        chk("rel_fs", {7'h0, frame_start}, 8'h01);
        bad = 0;
        for (int n = 0; n < 2 * PERIOD; n++) begin
            idle(1'b1);
            if (DATA_R !== 8'hFF || DATA_G !== 8'hFF || DATA_B !== 8'hFF) bad = 1;
        end
        chk("zero_banks", 8'(bad), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
